// File: rtl/mul_int.sv
// rtl/mul_int.sv - iterative unsigned shift-add multiplier with start/busy/valid handshake
module mul_int #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     x,
  input  logic [WIDTH-1:0]     y,
  output logic                 busy,
  output logic                 valid,
  output logic                 ovf,
  output logic [2*WIDTH-1:0]   p
);

  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [2*WIDTH:0]   acc_q, acc_d;
  logic [IW-1:0]      i_q, i_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic               ovf_q, ovf_d;
  logic               valid_q, valid_d;

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     upper;
  logic [2*WIDTH-1:0] shifted;

  // Upper half plus carry takes the partial product; shifting right drops the consumed multiplier bit.
  assign sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, a_q};
  assign upper   = acc_q[0] ? sum : acc_q[2*WIDTH:WIDTH];
  assign shifted = {upper, acc_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    acc_d   = acc_q;
    i_d     = i_q;
    p_d     = p_q;
    ovf_d   = ovf_q;
    valid_d = valid_q;
    // start wins over any iteration, including the final one.
    if (start) begin
      a_d     = x;
      acc_d   = {{(WIDTH+1){1'b0}}, y};
      i_d     = '0;
      state_d = S_RUN;
      valid_d = 1'b0;
    end else if (state_q == S_RUN) begin
      if (i_q == LAST) begin
        p_d     = shifted;
        ovf_d   = |shifted[2*WIDTH-1:WIDTH];
        valid_d = 1'b1;
        state_d = S_IDLE;
      end else begin
        acc_d   = {1'b0, shifted};
        i_d     = i_q + IW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      acc_q   <= '0;
      i_q     <= '0;
      p_q     <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      acc_q   <= acc_d;
      i_q     <= i_d;
      p_q     <= p_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  assign busy  = (state_q == S_RUN);
  assign valid = valid_q;
  assign ovf   = ovf_q;
  assign p     = p_q;

endmodule
